// File: rtl/wb_serial_pkg.sv
// Shared constants, state encoding and response byte helper for the
// byte-stream Wishbone debug master.
package wb_serial_pkg;

    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h45;
    localparam logic [7:0] RSP_TMO = 8'h54;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_BUS,
        ST_RESP
    } state_e;

    // Byte idx of a word, most significant byte first.
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    return w[31:24];
            2'd1:    return w[23:16];
            2'd2:    return w[15:8];
            default: return w[7:0];
        endcase
    endfunction

endpackage

// File: rtl/wb_serial_master_if.sv
// Wishbone classic master port bundle used between the serial master and
// the system interconnect.
interface wb_serial_master_if;

    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        wb_rty_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
    );

endinterface

// File: rtl/wb_serial_master.sv
// Parses 'R'/'W' command frames from a UART byte stream and runs one 32-bit
// Wishbone classic cycle per frame, returning read data or a status byte.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for a command byte, anything else is discarded
// ADDR    | shifting in 4 address bytes
// DATA    | shifting in 4 write data bytes
// BUS     | cyc/stb asserted, waiting for ack/err/rty or timeout
// RESP    | handing response bytes to the transmitter
module wb_serial_master
    import wb_serial_pkg::*;
#(
    parameter int timeout_cycles = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [7:0]                rx_data,
    input  logic                      rx_stb,
    output logic [7:0]                tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    output logic                      overrun,
    wb_serial_master_if.master        wb
);

    localparam int TMO_W = $clog2(timeout_cycles);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(timeout_cycles - 1);

    state_e           state_q, state_d;
    logic             we_q, we_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [31:0]      adr_q, adr_d;
    logic [31:0]      dat_q, dat_d;
    logic [31:0]      rdat_q, rdat_d;
    logic [7:0]       rsp_q, rsp_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             done_q, done_d;
    logic             cyc_q, cyc_d;
    logic             we_o_q, we_o_d;
    logic             tx_valid_q, tx_valid_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             overrun_q, overrun_d;
    logic             rd_ok;

    // Only a successful read returns more than one byte.
    assign rd_ok = (rsp_q == RSP_OK) && !we_q;

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        cnt_d      = cnt_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        rdat_d     = rdat_q;
        rsp_d      = rsp_q;
        tmo_d      = tmo_q;
        done_d     = done_q;
        cyc_d      = cyc_q;
        we_o_d     = we_o_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        overrun_d  = overrun_q;

        if (rx_stb && (state_q == ST_BUS || state_q == ST_RESP)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (rx_stb && (rx_data == CMD_RD || rx_data == CMD_WR)) begin
                    we_d    = (rx_data == CMD_WR);
                    cnt_d   = 2'd0;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (rx_stb) begin
                    adr_d = {adr_q[23:0], rx_data};
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        cnt_d = 2'd0;
                        if (we_q) begin
                            state_d = ST_DATA;
                        end else begin
                            state_d = ST_BUS;
                            cyc_d   = 1'b1;
                            we_o_d  = 1'b0;
                            tmo_d   = '0;
                            done_d  = 1'b0;
                        end
                    end
                end
            end
            ST_DATA: begin
                if (rx_stb) begin
                    dat_d = {dat_q[23:0], rx_data};
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        cnt_d   = 2'd0;
                        state_d = ST_BUS;
                        cyc_d   = 1'b1;
                        we_o_d  = 1'b1;
                        tmo_d   = '0;
                        done_d  = 1'b0;
                    end
                end
            end
            ST_BUS: begin
                if (done_q) begin
                    // Termination was sampled last edge; cyc drops one edge later.
                    cyc_d      = 1'b0;
                    we_o_d     = 1'b0;
                    cnt_d      = 2'd0;
                    state_d    = ST_RESP;
                    tx_valid_d = 1'b1;
                    tx_data_d  = rd_ok ? word_byte(rdat_q, 2'd0) : rsp_q;
                end else if (wb.wb_err_i || wb.wb_rty_i) begin
                    done_d = 1'b1;
                    rsp_d  = RSP_ERR;
                end else if (wb.wb_ack_i) begin
                    done_d = 1'b1;
                    rsp_d  = RSP_OK;
                    rdat_d = wb.wb_dat_i;
                end else if (tmo_q == TMO_LAST) begin
                    cyc_d      = 1'b0;
                    we_o_d     = 1'b0;
                    cnt_d      = 2'd0;
                    rsp_d      = RSP_TMO;
                    state_d    = ST_RESP;
                    tx_valid_d = 1'b1;
                    tx_data_d  = RSP_TMO;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (tx_valid_q && tx_ready) begin
                    if (rd_ok && cnt_q != 2'd3) begin
                        cnt_d     = cnt_q + 2'd1;
                        tx_data_d = word_byte(rdat_q, cnt_q + 2'd1);
                    end else begin
                        cnt_d      = 2'd0;
                        tx_valid_d = 1'b0;
                        state_d    = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            we_q       <= 1'b0;
            cnt_q      <= 2'd0;
            adr_q      <= '0;
            dat_q      <= '0;
            rdat_q     <= '0;
            rsp_q      <= '0;
            tmo_q      <= '0;
            done_q     <= 1'b0;
            cyc_q      <= 1'b0;
            we_o_q     <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            cnt_q      <= cnt_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            rdat_q     <= rdat_d;
            rsp_q      <= rsp_d;
            tmo_q      <= tmo_d;
            done_q     <= done_d;
            cyc_q      <= cyc_d;
            we_o_q     <= we_o_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            overrun_q  <= overrun_d;
        end
    end

    assign wb.wb_adr_o = adr_q;
    assign wb.wb_dat_o = dat_q;
    assign wb.wb_sel_o = {4{cyc_q}};
    assign wb.wb_we_o  = we_o_q;
    assign wb.wb_cyc_o = cyc_q;
    assign wb.wb_stb_o = cyc_q;

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_wb_serial_master.sv
// Directed scoreboard bench: frames go in over rx, expected response bytes and
// bus cycles are queued and compared as the master produces them.
module tb_wb_serial_master;
    import wb_serial_pkg::*;

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [31:0] dat;
        int          len;
    } bus_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_stb;
    logic        tx_ready;
    logic        use_t;

    logic [7:0]  tx_data0, tx_data1;
    logic        tx_valid0, tx_valid1, overrun0, overrun1;

    wb_serial_master_if wb0 ();
    wb_serial_master_if wb1 ();

    wb_serial_master dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_stb   (rx_stb & !use_t),
        .tx_data  (tx_data0),
        .tx_valid (tx_valid0),
        .tx_ready (tx_ready & !use_t),
        .overrun  (overrun0),
        .wb       (wb0.master)
    );

    wb_serial_master #(.timeout_cycles(16)) dut_t (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_stb   (rx_stb & use_t),
        .tx_data  (tx_data1),
        .tx_valid (tx_valid1),
        .tx_ready (tx_ready & use_t),
        .overrun  (overrun1),
        .wb       (wb1.master)
    );

    wire        cyc      = use_t ? wb1.wb_cyc_o : wb0.wb_cyc_o;
    wire        stb      = use_t ? wb1.wb_stb_o : wb0.wb_stb_o;
    wire        we       = use_t ? wb1.wb_we_o  : wb0.wb_we_o;
    wire [3:0]  sel      = use_t ? wb1.wb_sel_o : wb0.wb_sel_o;
    wire [31:0] adr      = use_t ? wb1.wb_adr_o : wb0.wb_adr_o;
    wire [31:0] dat_o    = use_t ? wb1.wb_dat_o : wb0.wb_dat_o;
    wire [7:0]  tx_data  = use_t ? tx_data1  : tx_data0;
    wire        tx_valid = use_t ? tx_valid1 : tx_valid0;
    wire        overrun  = use_t ? overrun1  : overrun0;

    // Slave model: 0 ack after s_wait cycles, 1 err at s_wait, 2 silent, 3 rty at s_wait.
    int          s_mode;
    int          s_wait;
    int          bus_cnt = 0;
    logic [31:0] wmem [16];
    logic [15:0] wvalid = '0;
    logic        s_ack, s_err, s_rty;
    logic [31:0] s_rdat;

    function automatic logic [31:0] default_word(input logic [31:0] a);
        return 32'hA5A5_0000 + {28'd0, a[5:2]};
    endfunction

    assign s_ack  = cyc && stb && s_mode == 0 && bus_cnt >= s_wait;
    assign s_err  = cyc && stb && s_mode == 1 && bus_cnt == s_wait;
    assign s_rty  = cyc && stb && s_mode == 3 && bus_cnt == s_wait;
    assign s_rdat = wvalid[adr[5:2]] ? wmem[adr[5:2]] : default_word(adr);

    assign wb0.wb_ack_i = s_ack;
    assign wb0.wb_err_i = s_err;
    assign wb0.wb_rty_i = s_rty;
    assign wb0.wb_dat_i = s_rdat;
    assign wb1.wb_ack_i = s_ack;
    assign wb1.wb_err_i = s_err;
    assign wb1.wb_rty_i = s_rty;
    assign wb1.wb_dat_i = s_rdat;

    always @(posedge clk) begin
        bus_cnt <= cyc ? bus_cnt + 1 : 0;
        if (s_ack && we) begin
            wmem[adr[5:2]]   <= dat_o;
            wvalid[adr[5:2]] <= 1'b1;
        end
    end

    int total  = 0;
    int passed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    logic [7:0] exp_tx [$];
    bus_t       exp_bus [$];
    logic       cyc_prev = 1'b0;
    int         cyc_len = 0;

    always @(negedge clk) begin
        if (!reset && tx_valid && tx_ready) begin
            check("tx_byte_expected", exp_tx.size() > 0, 1);
            if (exp_tx.size() > 0) check("tx_byte", tx_data, exp_tx.pop_front());
        end
        if (cyc && !cyc_prev) begin
            check("bus_expected", exp_bus.size() > 0, 1);
            if (exp_bus.size() > 0) begin
                check("bus_adr", adr, exp_bus[0].adr);
                check("bus_we", we, exp_bus[0].we);
                check("bus_sel", sel, 4'hF);
                check("bus_stb", stb, 1);
                if (exp_bus[0].we) check("bus_dat", dat_o, exp_bus[0].dat);
            end
            cyc_len <= 1;
        end else if (cyc) begin
            cyc_len <= cyc_len + 1;
        end else if (cyc_prev && exp_bus.size() > 0) begin
            if (exp_bus[0].len != 0) check("cyc_len", cyc_len, exp_bus[0].len);
            void'(exp_bus.pop_front());
        end
        cyc_prev <= cyc;
    end

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_stb  = 1'b1;
        @(posedge clk);
        #1;
        rx_stb  = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(word_byte(w, 2'(i)));
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) exp_tx.push_back(word_byte(w, 2'(i)));
    endtask

    task automatic push_bus(input logic [31:0] a, input logic w, input logic [31:0] d, input int len);
        bus_t b;
        b.adr = a;
        b.we  = w;
        b.dat = d;
        b.len = len;
        exp_bus.push_back(b);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while ((exp_tx.size() != 0 || exp_bus.size() != 0 || cyc || tx_valid) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, n < 500, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        rx_data  = 8'h00;
        rx_stb   = 1'b0;
        tx_ready = 1'b1;
        use_t    = 1'b0;
        s_mode   = 0;
        s_wait   = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cyc", wb0.wb_cyc_o, 0);
        check("rst_stb", wb0.wb_stb_o, 0);
        check("rst_we", wb0.wb_we_o, 0);
        check("rst_sel", wb0.wb_sel_o, 0);
        check("rst_adr", wb0.wb_adr_o, 0);
        check("rst_dat", wb0.wb_dat_o, 0);
        check("rst_tx_valid", tx_valid0, 0);
        check("rst_tx_data", tx_data0, 0);
        check("rst_overrun", overrun0, 0);
        check("rst_cyc_t", wb1.wb_cyc_o, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Write then read back through the zero-wait memory.
        push_bus(32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 2);
        exp_tx.push_back(RSP_OK);
        send_byte(CMD_WR);
        send_word(32'h0000_0010);
        send_word(32'hDEAD_BEEF);
        wait_done("write_done");
        push_bus(32'h0000_0010, 1'b0, 32'h0, 2);
        push_word(32'hDEAD_BEEF);
        send_byte(CMD_RD);
        send_word(32'h0000_0010);
        wait_done("read_done");
        check("no_overrun", overrun, 0);
        check("idle_sel", sel, 0);

        // Error on the third bus cycle.
        s_mode = 1;
        s_wait = 2;
        push_bus(32'h7000_0000, 1'b0, 32'h0, 4);
        exp_tx.push_back(RSP_ERR);
        send_byte(CMD_RD);
        send_word(32'h7000_0000);
        wait_done("err_done");

        // Retry is reported like an error.
        s_mode = 3;
        s_wait = 0;
        push_bus(32'h0000_0020, 1'b0, 32'h0, 2);
        exp_tx.push_back(RSP_ERR);
        send_byte(CMD_RD);
        send_word(32'h0000_0020);
        wait_done("rty_done");

        // Silent slave against the 16-cycle timeout instance.
        use_t  = 1'b1;
        s_mode = 2;
        push_bus(32'h0000_0020, 1'b0, 32'h0, 16);
        exp_tx.push_back(RSP_TMO);
        send_byte(CMD_RD);
        send_word(32'h0000_0020);
        wait_done("tmo_done");
        use_t = 1'b0;
        @(posedge clk);
        #1;

        // Junk bytes, slow slave and a byte arriving mid-cycle.
        s_mode = 0;
        s_wait = 20;
        push_bus(32'h7000_1000, 1'b0, 32'h0, 22);
        push_word(default_word(32'h7000_1000));
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(CMD_RD);
        send_word(32'h7000_1000);
        repeat (3) @(posedge clk);
        #1;
        send_byte(8'h33);
        wait_done("slow_done");
        check("overrun_set", overrun, 1);

        // Transmitter stalls while the first read byte is waiting.
        s_wait   = 0;
        tx_ready = 1'b0;
        push_bus(32'h0000_0010, 1'b0, 32'h0, 2);
        push_word(32'hDEAD_BEEF);
        send_byte(CMD_RD);
        send_word(32'h0000_0010);
        for (int n = 0; n < 20 && !tx_valid; n++) begin
            @(posedge clk);
            #1;
        end
        check("stall_tx_valid", tx_valid, 1);
        repeat (10) begin
            @(posedge clk);
            #1;
            check("stall_tx_data", tx_data, 8'hDE);
        end
        tx_ready = 1'b1;
        wait_done("stall_done");

        // Reset in the middle of a bus cycle, then a fresh write/read.
        s_mode = 2;
        push_bus(32'h0000_0040, 1'b0, 32'h0, 0);
        send_byte(CMD_RD);
        send_word(32'h0000_0040);
        repeat (4) @(posedge clk);
        #1;
        check("pre_reset_cyc", cyc, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("reset_cyc", cyc, 0);
        check("reset_stb", stb, 0);
        check("reset_tx_valid", tx_valid, 0);
        check("reset_overrun", overrun, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        s_mode = 0;
        push_bus(32'h0000_0040, 1'b1, 32'h1234_5678, 2);
        exp_tx.push_back(RSP_OK);
        send_byte(CMD_WR);
        send_word(32'h0000_0040);
        send_word(32'h1234_5678);
        wait_done("post_reset_write");
        push_bus(32'h0000_0040, 1'b0, 32'h0, 2);
        push_word(32'h1234_5678);
        send_byte(CMD_RD);
        send_word(32'h0000_0040);
        wait_done("post_reset_read");

        check("tx_queue_empty", exp_tx.size(), 0);
        check("bus_queue_empty", exp_bus.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/wb_serial_master.md
# wb_serial_master

Byte-stream-driven Wishbone bus master for host debug access to the SoC. It parses read/write command frames arriving from a UART receiver and issues single 32-bit Wishbone classic cycles on a spare master port of the system interconnect, alongside the LM32 instruction and data masters. It returns read data or status bytes to a UART transmitter. This gives the host peek/poke access to BRAM and peripherals without CPU involvement.

## Interface
- `timeout_cycles`, default 1024: bus cycles to wait for ack/err/rty before abandoning a transfer; minimum 2.
- `clk` in 1: system clock; the only clock.
- `reset` in 1: synchronous, active-high reset.
- `rx_data` in 8: received byte.
- `rx_stb` in 1: one-cycle strobe, `rx_data` valid. There is no backpressure.
- `tx_data` out 8: response byte.
- `tx_valid` out 1: `tx_data` valid; held until accepted.
- `tx_ready` in 1: transmitter accepts the byte on a clock edge where `tx_valid` and `tx_ready` are both high.
- `overrun` out 1: sticky flag; a byte arrived while the block could not accept it. Cleared only by reset.
- `wb_adr_o` out 32, `wb_dat_o` out 32, `wb_dat_i` in 32, `wb_sel_o` out 4, `wb_we_o` out 1, `wb_cyc_o` out 1, `wb_stb_o` out 1, `wb_ack_i` in 1, `wb_err_i` in 1, `wb_rty_i` in 1: Wishbone classic master port.

## Operation
- Frame formats, all multi-byte fields big-endian (MSB first):
  - Read: `0x52` ('R') followed by 4 address bytes.
  - Write: `0x57` ('W') followed by 4 address bytes and 4 data bytes.
- Responses:
  - Read OK: 4 data bytes, MSB first.
  - Write OK: `0x4B` ('K').
  - Bus error or retry: `0x45` ('E').
  - Timeout: `0x54` ('T').
- `wb_rty_i` is treated exactly like `wb_err_i`. Retry is not performed.
- `wb_sel_o` is always `4'hF` during a cycle and `0` otherwise. `wb_adr_o` is passed through unmodified, with no alignment masking.
- FSM states:
  - IDLE: an `rx_stb` with `0x52` or `0x57` latches `we` and goes to ADDR. Any other byte is silently discarded and the FSM stays in IDLE.
  - ADDR: shifts 4 bytes into the address register. After the 4th byte, go to DATA if write, else BUS.
  - DATA: shifts 4 bytes into the data register, then goes to BUS.
  - BUS: `cyc`/`stb` high. Exit on ack, err, rty, or timeout, then go to RESP.
  - RESP: presents the response bytes one at a time. After the last byte is accepted, return to IDLE.
- A 2-bit byte counter is shared by ADDR, DATA, and RESP and is cleared on every state entry.
- `rx_stb` in BUS or RESP drops the byte and sets `overrun`. The frame in progress completes normally.
- There is no inter-byte timeout in ADDR/DATA. A host resynchronises by sending 9 non-command bytes, or the system is reset.

## Timing
- Reset values: all outputs are 0, including `wb_cyc_o`, `wb_stb_o`, `wb_we_o`, `wb_sel_o`, `wb_adr_o`, `wb_dat_o`, `tx_valid`, `tx_data`, and `overrun`. The FSM is in IDLE with counters cleared.
- A reset asserted mid-cycle drops `cyc`/`stb` at that edge. Any pending response is discarded.
- Bus cycle start: `wb_cyc_o`, `wb_stb_o`, `wb_adr_o`, `wb_we_o`, and `wb_dat_o` are registered and go high on the edge after the strobe of the final frame byte.
- Bus cycle end:
  - `cyc`/`stb` fall on the edge after the edge that samples ack/err/rty high, so a zero-wait slave gives exactly 2 cycles of `cyc`.
  - Read data is captured on the ack sampling edge.
- Ack, err, and rty asserted together: err/rty take priority.
- Timeout: a counter clears on BUS entry and increments each BUS cycle. If it reaches `timeout_cycles-1` with no ack/err/rty sampled, `cyc`/`stb` fall on the next edge and the response is 'T'. An ack sampled on the same edge as the timeout wins.
- `tx_valid` rises the cycle after BUS exit. `tx_data` is stable while `tx_valid` is high and not yet accepted. A new byte is presented on the edge after each transfer, so back-to-back transfers are possible when `tx_ready` is held high.
- The FSM is in IDLE on the edge after the final response byte transfer, and a command strobed on that next cycle is accepted.

## Structure
- Shared package `wb_serial_pkg` holds:
  - Command constants `CMD_RD=8'h52` and `CMD_WR=8'h57`.
  - Response constants `RSP_OK=8'h4B`, `RSP_ERR=8'h45`, and `RSP_TMO=8'h54`.
  - The FSM state encoding.
- Single module; no sub-module is warranted. The timeout counter width is `$clog2(timeout_cycles)`.

## Test plan
- Write then read with a zero-wait BRAM model:
  - Stimulus: `57 00 00 00 10 DE AD BE EF`, then `52 00 00 00 10`.
  - Required response: `4B`, then `DE AD BE EF`.
  - Bus check: `adr=0x00000010`, `sel=F`, `cyc` exactly 2 cycles each.
- Slave asserts `wb_err_i` on the third cycle of a read to `0x70000000` -> single `45` byte, `cyc` low the next cycle, block returns to IDLE.
- Slave never responds, `timeout_cycles=16` -> `cyc` high for exactly 16 cycles, then `54` is returned.
- Bytes `00 FF 52 70 00 10 00` with a slave holding ack low for 20 cycles and an extra `rx_stb` during BUS:
  - `00` and `FF` are ignored.
  - The read to `0x70001000` completes.
  - `overrun=1`.
- `tx_ready` low for 10 cycles during a read response -> `tx_data` holds `DE` and no bytes are lost or duplicated.
- Reset pulsed during BUS -> `cyc`/`stb`/`tx_valid` are 0 next cycle, and a fresh frame then completes correctly.
